// File: rtl/cache_types_pkg.sv
// Shared cache/memory types: burst responder FSM states and the
// burst geometry used by both the line adapter and the memory side.
package cache_types;

    localparam int BMEM_BURST_LEN  = 4;
    localparam int BMEM_BEAT_WIDTH = 64;

    typedef enum logic [2:0] {
        R_IDLE     = 3'd0,
        R_WCOLLECT = 3'd1,
        R_WCOMMIT  = 3'd2,
        R_RLATENCY = 3'd3,
        R_RBURST   = 3'd4
    } responder_state_t;

endpackage

// File: rtl/burst_mem_array.sv
// Backing line store: DEPTH_LINES x LINE_WIDTH, one write port and one
// registered read port (read every cycle). Ports: clk, wr_en/wr_idx/wr_line,
// rd_idx, rd_line. Contents are not reset.
module burst_mem_array #(
    parameter int DEPTH_LINES = 256,
    parameter int LINE_WIDTH  = 256,
    localparam int IDX_W      = $clog2(DEPTH_LINES)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [LINE_WIDTH-1:0] wr_line,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [LINE_WIDTH-1:0] rd_line
);

    logic [LINE_WIDTH-1:0] mem [DEPTH_LINES];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_line;
        end
        rd_line <= mem[rd_idx];
    end

endmodule

// File: rtl/burst_mem_responder.sv
// Memory-side burst responder: collects BURST_LEN write beats into a line,
// commits it to burst_mem_array, and returns lines as BURST_LEN read beats
// after READ_LATENCY cycles. Ports: clk, rst (sync, active high), bmem_addr,
// bmem_read, bmem_write, bmem_wdata in; bmem_ready, bmem_raddr, bmem_rdata,
// bmem_rvalid out. Option macro BMEM_CRIT_WORD_FIRST_EN: reads start at the
// addressed beat and wrap modulo BURST_LEN.
module burst_mem_responder
    import cache_types::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int BEAT_WIDTH   = BMEM_BEAT_WIDTH,
    parameter int BURST_LEN    = BMEM_BURST_LEN,
    parameter int DEPTH_LINES  = 256,
    parameter int READ_LATENCY = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] bmem_addr,
    input  logic                  bmem_read,
    input  logic                  bmem_write,
    input  logic [BEAT_WIDTH-1:0] bmem_wdata,
    output logic                  bmem_ready,
    output logic [ADDR_WIDTH-1:0] bmem_raddr,
    output logic [BEAT_WIDTH-1:0] bmem_rdata,
    output logic                  bmem_rvalid
);

    localparam int LINE_W = BEAT_WIDTH * BURST_LEN;
    localparam int OFS    = $clog2(LINE_W / 8);
    localparam int IDX_W  = $clog2(DEPTH_LINES);
    localparam int CNT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int LAT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [LAT_W-1:0] LAT_INIT  = LAT_W'(READ_LATENCY - 1);

    responder_state_t  state;
    logic [CNT_W-1:0]  beat_cnt;
    logic [CNT_W-1:0]  start_beat;
    logic [CNT_W-1:0]  beat_sel;
    logic [LAT_W-1:0]  lat_cnt;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic [LINE_W-1:0] line_buf;
    logic [LINE_W-1:0] rd_line;
    logic              wr_en;

    assign wr_en = (state == R_WCOMMIT);

    // In idle the array tracks the incoming address so the line is already
    // registered even for a one-cycle latency; afterwards it holds the
    // latched request line.
    assign rd_idx = (state == R_IDLE) ? bmem_addr[OFS+:IDX_W]
                                      : bmem_raddr[OFS+:IDX_W];

`ifdef BMEM_CRIT_WORD_FIRST_EN
    localparam int BOFS = $clog2(BEAT_WIDTH / 8);
    assign start_beat = bmem_raddr[BOFS+:CNT_W];
`else
    assign start_beat = '0;
`endif

    // Beat to load into rdata at this edge: first beat on burst entry,
    // next beat while bursting; CNT_W arithmetic gives the wrap.
    assign beat_sel = start_beat
                    + ((state == R_RBURST) ? beat_cnt + 1'b1 : '0);

    burst_mem_array #(
        .DEPTH_LINES (DEPTH_LINES),
        .LINE_WIDTH  (LINE_W)
    ) u_array (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_line (line_buf),
        .rd_idx  (rd_idx),
        .rd_line (rd_line)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= R_IDLE;
            bmem_ready  <= 1'b0;
            bmem_rvalid <= 1'b0;
            bmem_rdata  <= '0;
            bmem_raddr  <= '0;
            beat_cnt    <= '0;
            lat_cnt     <= '0;
            wr_idx      <= '0;
            line_buf    <= '0;
        end else begin
            unique case (state)
                R_IDLE: begin
                    if (!bmem_ready) begin
                        // ready returns one cycle after reset or commit
                        bmem_ready <= 1'b1;
                    end else if (bmem_write) begin
                        line_buf[0+:BEAT_WIDTH] <= bmem_wdata;
                        wr_idx   <= bmem_addr[OFS+:IDX_W];
                        beat_cnt <= CNT_W'(1);
                        state    <= R_WCOLLECT;
                    end else if (bmem_read) begin
                        bmem_raddr <= bmem_addr;
                        lat_cnt    <= LAT_INIT;
                        bmem_ready <= 1'b0;
                        state      <= R_RLATENCY;
                    end
                end
                R_WCOLLECT: begin
                    if (bmem_write) begin
                        line_buf[beat_cnt*BEAT_WIDTH+:BEAT_WIDTH]
                            <= bmem_wdata;
                        if (beat_cnt == LAST_BEAT) begin
                            bmem_ready <= 1'b0;
                            state      <= R_WCOMMIT;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                R_WCOMMIT: begin
                    state <= R_IDLE;
                end
                R_RLATENCY: begin
                    if (lat_cnt == '0) begin
                        bmem_rdata  <= rd_line[beat_sel*BEAT_WIDTH+:BEAT_WIDTH];
                        bmem_rvalid <= 1'b1;
                        beat_cnt    <= '0;
                        state       <= R_RBURST;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                R_RBURST: begin
                    if (beat_cnt == LAST_BEAT) begin
                        bmem_rvalid <= 1'b0;
                        bmem_ready  <= 1'b1;
                        state       <= R_IDLE;
                    end else begin
                        bmem_rdata <= rd_line[beat_sel*BEAT_WIDTH+:BEAT_WIDTH];
                        beat_cnt   <= beat_cnt + 1'b1;
                    end
                end
                default: state <= R_IDLE;
            endcase
        end
    end

    // A simultaneous read and write in idle is a protocol violation.
    a_no_rw_collision : assert property (@(posedge clk) disable iff (rst)
        !(state == R_IDLE && bmem_ready && bmem_read && bmem_write));

endmodule

// File: tb/tb_burst_mem_responder.sv
// Scoreboard bench for burst_mem_responder: directed writes/reads push
// expected beats; a negedge monitor pops and compares each rvalid beat.
module tb_burst_mem_responder;

    typedef logic [63:0] beats_t [4];

    typedef struct {
        logic [63:0] data;
        logic [31:0] addr;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] bmem_addr;
    logic        bmem_read;
    logic        bmem_write;
    logic [63:0] bmem_wdata;
    logic        bmem_ready;
    logic [31:0] bmem_raddr;
    logic [63:0] bmem_rdata;
    logic        bmem_rvalid;

    int   cyc;
    int   vectors;
    int   miscompares;
    exp_t sb_q [$];

    burst_mem_responder dut (
        .clk         (clk),
        .rst         (rst),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_raddr  (bmem_raddr),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every rvalid beat must match the head of the scoreboard
    // in data, returned address and arrival cycle.
    always @(negedge clk) begin
        if (!rst && bmem_rvalid) begin
            exp_t e;
            vectors = vectors + 1;
            if (sb_q.size() == 0) begin
                miscompares = miscompares + 1;
                $display("FAIL beat_unexpected: rdata=%h raddr=%h cyc=%0d",
                         bmem_rdata, bmem_raddr, cyc);
            end else begin
                e = sb_q.pop_front();
                if (bmem_rdata !== e.data || bmem_raddr !== e.addr
                    || cyc != e.cyc) begin
                    miscompares = miscompares + 1;
                    $display("FAIL beat: got d=%h a=%h c=%0d exp d=%h a=%h c=%0d",
                             bmem_rdata, bmem_raddr, cyc,
                             e.data, e.addr, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %h exp %h", name, act, exp);
        end
    endtask

    // Called at a negedge; waits (bounded) for ready.
    task automatic wait_ready();
        int n = 0;
        while (!bmem_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bmem_ready) begin
            vectors = vectors + 1;
            miscompares = miscompares + 1;
            $display("FAIL ready_timeout: ready=%b exp 1 at cyc %0d",
                     bmem_ready, cyc);
        end
    endtask

    task automatic write_line(input logic [31:0] a, input beats_t d,
                              input bit gap);
        wait_ready();
        bmem_addr  = a;
        bmem_write = 1'b1;
        bmem_wdata = d[0];
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            if (gap && i == 2) begin
                bmem_write = 1'b0;
                bmem_wdata = 64'hDEAD_DEAD_DEAD_DEAD;
                @(negedge clk);
            end
            bmem_write = 1'b1;
            bmem_wdata = d[i];
        end
        @(negedge clk);
        bmem_write = 1'b0;
    endtask

    task automatic read_line(input logic [31:0] a, input beats_t d,
                             output int acc);
        int start;
`ifdef BMEM_CRIT_WORD_FIRST_EN
        start = int'(a[4:3]);
`else
        start = 0;
`endif
        wait_ready();
        bmem_addr = a;
        bmem_read = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        for (int k = 0; k < 4; k++) begin
            exp_t e;
            e.data = d[(start + k) % 4];
            e.addr = a;
            e.cyc  = acc + 8 + k;
            sb_q.push_back(e);
        end
        @(negedge clk);
        bmem_read = 1'b0;
    endtask

    beats_t la, lb, lc, ld;
    int     acc;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        bmem_addr   = '0;
        bmem_read   = 1'b0;
        bmem_write  = 1'b0;
        bmem_wdata  = '0;
        la = '{64'hA0A0_0000_0000_00A0, 64'hA1A1_1111_1111_11A1,
               64'hA2A2_2222_2222_22A2, 64'hA3A3_3333_3333_33A3};
        lb = '{64'hB0B0_0000_0000_00B0, 64'hB1B1_1111_1111_11B1,
               64'hB2B2_2222_2222_22B2, 64'hB3B3_3333_3333_33B3};
        lc = '{64'hC0C0_0000_0000_00C0, 64'hC1C1_1111_1111_11C1,
               64'hC2C2_2222_2222_22C2, 64'hC3C3_3333_3333_33C3};
        ld = '{64'hD0D0_0000_0000_00D0, 64'hD1D1_1111_1111_11D1,
               64'hD2D2_2222_2222_22D2, 64'hD3D3_3333_3333_33D3};

        // reset held 3 cycles, ready rises right after release
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_ready", 64'(bmem_ready), 64'd0);
            chk("rst_rvalid", 64'(bmem_rvalid), 64'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 64'(bmem_ready), 64'd1);

        // back-to-back write then read
        write_line(32'h100, la, 1'b0);
        read_line(32'h100, la, acc);

        // write with a stall gap between beats
        write_line(32'h140, la, 1'b1);
        read_line(32'h140, la, acc);

        // alias: DEPTH_LINES*32 bytes above maps onto the same line
        write_line(32'h100 + 32'd256 * 32'd32, lb, 1'b0);
        read_line(32'h100, lb, acc);

        // partial write aborted by reset leaves old data intact
        write_line(32'h200, lc, 1'b0);
        read_line(32'h200, lc, acc);
        wait_ready();
        bmem_addr  = 32'h200;
        bmem_write = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bmem_wdata = ld[i];
            @(negedge clk);
        end
        bmem_write = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        read_line(32'h200, lc, acc);

        // reset during a read burst after two beats
        read_line(32'h200, lc, acc);
        while (cyc < acc + 9) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        sb_q.delete();
        @(negedge clk);
        chk("rvalid_after_burst_rst", 64'(bmem_rvalid), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // offset read: wrapped order with the option, linear without
        write_line(32'h300, la, 1'b0);
        read_line(32'h310, la, acc);

        wait_ready();
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
